// File: rtl/slc3_mmio_bridge.sv
// SLC-3 CPU <-> SRAM / board I/O bridge: valid/ready request channel, wait-stated
// SRAM strobes, memory-mapped switch, LED and hex-display registers.
module slc3_mmio_bridge #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter int                NUM_HEX     = 2,
    parameter int                SW_W        = 10,
    parameter logic [ADDR_W-1:0] IO_BASE     = ADDR_W'(16'hFFF0)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    output logic [DATA_W-1:0]     SRAM_WDATA,
    input  logic [DATA_W-1:0]     SRAM_RDATA,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_OE_N,
    output logic                  SRAM_WE_N,
    input  logic [SW_W-1:0]       SW,
    output logic [SW_W-1:0]       LED,
    output logic [NUM_HEX*16-1:0] HEX_NIB
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES + 1);
    localparam int               HEX_CP   = (DATA_W < 16) ? DATA_W : 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRAM_RD,
        S_SRAM_WR,
        S_IO,
        S_RESP
    } state_t;

    function automatic logic [15:0] to_hex16(input logic [DATA_W-1:0] d);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < HEX_CP; i++) r[i] = d[i];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] from_hex16(input logic [15:0] h);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < HEX_CP; i++) r[i] = h[i];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] zext_sw(input logic [SW_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < SW_W; i++) r[i] = s[i];
        return r;
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic               r_ready;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [ADDR_W-1:0]  r_sram_addr;
    logic [DATA_W-1:0]  r_sram_wdata;
    logic               r_ce_n;
    logic               r_oe_n;
    logic               r_we_n;
    logic [SW_W-1:0]    r_sw_s1;
    logic [SW_W-1:0]    r_sw_s2;
    logic [SW_W-1:0]    r_led;
    logic [15:0]        r_hex [NUM_HEX];

    logic [ADDR_W-1:0]      w_off;
    logic [DATA_W-1:0]      w_io_rdata;
    logic [NUM_HEX*16-1:0]  w_hex_nib;

    // The latched address/data registers double as the I/O request operands;
    // the strobes stay high on I/O accesses so the SRAM ignores them.
    assign w_off = r_sram_addr - IO_BASE;

    always_comb begin
        w_io_rdata = '0;
        if (w_off == ADDR_W'(0)) begin
            w_io_rdata = zext_sw(r_sw_s2);
        end else if (w_off == ADDR_W'(1)) begin
            w_io_rdata = zext_sw(r_led);
        end else begin
            for (int k = 0; k < NUM_HEX; k++) begin
                if (w_off == ADDR_W'(k + 2)) w_io_rdata = from_hex16(r_hex[k]);
            end
        end
    end

    always_comb begin
        w_hex_nib = '0;
        for (int k = 0; k < NUM_HEX; k++) w_hex_nib[k*16 +: 16] = r_hex[k];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_ready      <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_ce_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_we_n       <= 1'b1;
            r_sw_s1      <= '0;
            r_sw_s2      <= '0;
            r_led        <= '0;
            for (int k = 0; k < NUM_HEX; k++) r_hex[k] <= '0;
        end else begin
            r_sw_s1     <= SW;
            r_sw_s2     <= r_sw_s1;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_ready      <= 1'b0;
                        r_we         <= req_we;
                        r_sram_addr  <= req_addr;
                        r_sram_wdata <= req_wdata;
                        r_cnt        <= '0;
                        if (req_addr >= IO_BASE) r_state <= S_IO;
                        else if (req_we)         r_state <= S_SRAM_WR;
                        else                     r_state <= S_SRAM_RD;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                // First cycle is address setup; strobes then stay low WAIT_CYCLES+1 cycles.
                S_SRAM_RD: begin
                    if (r_cnt == '0) begin
                        r_ce_n <= 1'b0;
                        r_oe_n <= 1'b0;
                        r_cnt  <= CNT_W'(1);
                    end else if (r_cnt == CNT_LAST) begin
                        r_ce_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        r_rsp_rdata <= SRAM_RDATA;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SRAM_WR: begin
                    if (r_cnt == '0) begin
                        r_ce_n <= 1'b0;
                        r_we_n <= 1'b0;
                        r_cnt  <= CNT_W'(1);
                    end else if (r_cnt == CNT_LAST) begin
                        r_ce_n      <= 1'b1;
                        r_we_n      <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_IO: begin
                    if (r_cnt == '0) begin
                        r_cnt <= CNT_W'(1);
                    end else begin
                        if (r_we) begin
                            if (w_off == ADDR_W'(1)) r_led <= r_sram_wdata[SW_W-1:0];
                            for (int k = 0; k < NUM_HEX; k++) begin
                                if (w_off == ADDR_W'(k + 2)) r_hex[k] <= to_hex16(r_sram_wdata);
                            end
                            r_rsp_rdata <= '0;
                        end else begin
                            r_rsp_rdata <= w_io_rdata;
                        end
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign SRAM_ADDR  = r_sram_addr;
    assign SRAM_WDATA = r_sram_wdata;
    assign SRAM_CE_N  = r_ce_n;
    assign SRAM_OE_N  = r_oe_n;
    assign SRAM_WE_N  = r_we_n;
    assign LED        = r_led;
    assign HEX_NIB    = w_hex_nib;

endmodule

// File: tb/tb_slc3_mmio_bridge.sv
// Scoreboard bench for slc3_mmio_bridge: stimulus pushes expected responses,
// a monitor pops them on rsp_valid and checks data and arrival cycle.
module tb_slc3_mmio_bridge;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] SRAM_ADDR, SRAM_WDATA, SRAM_RDATA;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
    logic [9:0]  SW, LED;
    logic [31:0] HEX_NIB;

    slc3_mmio_bridge #(
        .DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2), .NUM_HEX(2), .SW_W(10), .IO_BASE(16'hFFF0)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA), .SRAM_RDATA(SRAM_RDATA),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SW(SW), .LED(LED), .HEX_NIB(HEX_NIB)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    int          oe_run = 0, oe_last = 0, oe_total = 0;
    int          we_run = 0, we_last = 0, we_unstable = 0, overlap = 0;
    logic [15:0] we_addr = '0, we_wdata = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Response monitor
    always @(negedge Clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Strobe watcher
    always @(negedge Clk) begin
        if (!SRAM_OE_N) begin
            oe_run++;
            oe_total++;
        end else if (oe_run != 0) begin
            oe_last = oe_run;
            oe_run  = 0;
        end
        if (!SRAM_WE_N) begin
            if (we_run == 0) begin
                we_addr  = SRAM_ADDR;
                we_wdata = SRAM_WDATA;
            end else if (SRAM_ADDR !== we_addr || SRAM_WDATA !== we_wdata) begin
                we_unstable++;
            end
            we_run++;
        end else if (we_run != 0) begin
            we_last = we_run;
            we_run  = 0;
        end
        if (!SRAM_OE_N && !SRAM_WE_N) overlap++;
    end

    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp, input int lat, input bit push);
        int w;
        w = 0;
        @(negedge Clk);
        while (!req_ready && w < 30) begin
            @(negedge Clk);
            w++;
        end
        chk("req_ready_before_issue", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        if (push) sb.push_back('{rdata: exp, cyc: cyc + 1 + lat});
        @(negedge Clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int w;
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(negedge Clk);
            w++;
        end
        chk({name, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        @(negedge Clk);
        chk({name, "_ready_next"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oe_snap;
        int w;
        Reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        SRAM_RDATA = 16'hBEEF;
        SW         = '0;

        // 1. reset values and first ready edge
        repeat (3) @(negedge Clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
        chk("rst_sram_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_sram_wdata", 32'(SRAM_WDATA), 32'd0);
        chk("rst_led", 32'(LED), 32'd0);
        chk("rst_hex", HEX_NIB, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("ready_first_edge", 32'(req_ready), 32'd1);

        // 2. SRAM read with wait states
        issue(1'b0, 16'h1234, 16'h0000, 16'hBEEF, 4, 1'b1);
        wait_rsp("sram_rd");
        chk("rd_oe_width", 32'(oe_last), 32'd3);
        chk("rd_no_we", 32'(we_last), 32'd0);

        // 3. SRAM write
        oe_snap = oe_total;
        issue(1'b1, 16'h0042, 16'hA5A5, 16'h0000, 4, 1'b1);
        wait_rsp("sram_wr");
        chk("wr_we_width", 32'(we_last), 32'd3);
        chk("wr_addr", 32'(we_addr), 32'h0042);
        chk("wr_wdata", 32'(we_wdata), 32'hA5A5);
        chk("wr_stable", 32'(we_unstable), 32'd0);
        chk("wr_oe_high", 32'(oe_total), 32'(oe_snap));
        chk("wr_no_overlap", 32'(overlap), 32'd0);

        // address just below IO_BASE is SRAM
        SRAM_RDATA = 16'h1357;
        issue(1'b0, 16'hFFEF, 16'h0000, 16'h1357, 4, 1'b1);
        wait_rsp("sram_edge");

        // 4. hex registers
        issue(1'b1, 16'hFFF3, 16'hC0DE, 16'h0000, 2, 1'b1);
        wait_rsp("hex1_wr");
        chk("hex1_value", HEX_NIB, 32'hC0DE_0000);
        issue(1'b0, 16'hFFF3, 16'h0000, 16'hC0DE, 2, 1'b1);
        wait_rsp("hex1_rd");
        issue(1'b1, 16'hFFF2, 16'h1234, 16'h0000, 2, 1'b1);
        wait_rsp("hex0_wr");
        chk("hex_both", HEX_NIB, 32'hC0DE_1234);
        issue(1'b1, 16'hFFF4, 16'hFFFF, 16'h0000, 2, 1'b1);
        wait_rsp("unmapped_wr");
        chk("unmapped_no_effect", HEX_NIB, 32'hC0DE_1234);
        issue(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 2, 1'b1);
        wait_rsp("top_addr_rd");

        // LED register, truncated to SW_W bits
        issue(1'b1, 16'hFFF1, 16'hFFFF, 16'h0000, 2, 1'b1);
        wait_rsp("led_wr");
        chk("led_value", 32'(LED), 32'h3FF);
        issue(1'b0, 16'hFFF1, 16'h0000, 16'h03FF, 2, 1'b1);
        wait_rsp("led_rd");

        // 5. switches through the synchroniser
        SW = 10'h2AA;
        repeat (3) @(negedge Clk);
        issue(1'b0, 16'hFFF0, 16'h0000, 16'h02AA, 2, 1'b1);
        wait_rsp("sw_rd");
        issue(1'b1, 16'hFFF0, 16'h5555, 16'h0000, 2, 1'b1);
        wait_rsp("sw_wr");
        chk("sw_wr_led", 32'(LED), 32'h3FF);
        chk("sw_wr_hex", HEX_NIB, 32'hC0DE_1234);
        issue(1'b0, 16'hFFF0, 16'h0000, 16'h02AA, 2, 1'b1);
        wait_rsp("sw_rd2");

        // 6. reset in the middle of an SRAM read
        issue(1'b0, 16'h0200, 16'h0000, 16'h0000, 4, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        chk("abort_oe_active", 32'(SRAM_OE_N), 32'd0);
        Reset_n = 1'b0;
        #1;
        chk("abort_strobes", {29'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}, 32'd7);
        chk("abort_hex", HEX_NIB, 32'd0);
        chk("abort_led", 32'(LED), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (8) @(negedge Clk);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        issue(1'b0, 16'hFFF3, 16'h0000, 16'h0000, 2, 1'b1);
        wait_rsp("post_reset_rd");

        w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge Clk);
            w++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
